// File: rtl/hilo_maddu_unit.sv
// Iterative unsigned MULTU/MADDU unit with the architectural HI/LO pair.
// Shift-add over WIDTH cycles in the background; stalls dependent EX instructions.
module hilo_maddu_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             accum,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_req,
    input  logic             hi_or_lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            commit;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   count;
    logic [AW-1:0]   acc_sum;

    // One partial product per cycle; carry out of the top bit is discarded.
    assign acc_sum = mplier[0] ? AW'(acc + mcand) : acc;

    assign busy    = (state_q == RUN);
    assign stall   = busy & (start | mf_req);
    assign mf_data = hi_or_lo ? hi : lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand load on accept, shift-add while running, HI/LO commit on last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, op_a};
                mplier <= op_b;
                acc    <= accum ? {hi, lo} : '0;
                count  <= CW'(WIDTH);
            end else if (state_q == RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - CW'(1);
            end
            if (commit) begin
                {hi, lo} <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_hilo_maddu_unit.sv
// Directed self-checking bench for hilo_maddu_unit (WIDTH = 32).
module tb_hilo_maddu_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         accum;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         mf_req;
    logic         hi_or_lo;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] mf_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    hilo_maddu_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .accum    (accum),
        .op_a     (op_a),
        .op_b     (op_b),
        .mf_req   (mf_req),
        .hi_or_lo (hi_or_lo),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .mf_data  (mf_data),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one op, check HI/LO hold, latency, done pulse and final result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic acc_mode, input logic [63:0] exp);
        logic [63:0] prev;
        int n;
        prev  = {hi, lo};
        start = 1'b1;
        accum = acc_mode;
        op_a  = a;
        op_b  = b;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            chk({tag, "_hold"}, {hi, lo}, prev);
            chk({tag, "_nodone"}, 64'(done), 64'd0);
            n++;
            tick();
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_result"}, {hi, lo}, exp);
        tick();
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; accum = 1'b0; op_a = '0; op_b = '0;
        mf_req = 1'b0; hi_or_lo = 1'b0;
        do_reset();

        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_hilo",  {hi, lo},   64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_mf",    64'(mf_data), 64'd0);

        run_op("multu_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_op("maddu_2x3",  32'd2, 32'd3, 1'b1, 64'hFFFF_FFFE_0000_0007);

        do_reset();
        run_op("wrap_mul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_op("wrap_mad", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFC_0000_0002);

        // MFHI issued 5 cycles after accept must stall for the remaining 27 busy cycles.
        start = 1'b1; accum = 1'b0; op_a = 32'h1234_5678; op_b = 32'h10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        mf_req = 1'b1; hi_or_lo = 1'b1;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("mf_stall_cycles", 64'(n), 64'd27);
        chk("mf_busy_clear", 64'(busy), 64'd0);
        chk("mf_hi", 64'(mf_data), 64'h1);
        hi_or_lo = 1'b0;
        #1;
        chk("mf_lo", 64'(mf_data), 64'h2345_6780);
        chk("mf_lo_nostall", 64'(stall), 64'd0);
        mf_req = 1'b0;

        // MADDU held in EX behind a running MULTU: accepted right after commit.
        start = 1'b1; accum = 1'b0; op_a = 32'd100; op_b = 32'd200;
        tick();
        accum = 1'b1; op_a = 32'd300; op_b = 32'd400;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("held_stall_cycles", 64'(n), 64'd32);
        chk("held_first_result", {hi, lo}, 64'd20000);
        chk("held_done", 64'(done), 64'd1);
        tick();
        start = 1'b0;
        chk("held_accepted_busy", 64'(busy), 64'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("held_latency", 64'(n), 64'd32);
        chk("held_sum", {hi, lo}, 64'd140000);

        // Reset in the middle of a run aborts it without a done pulse.
        start = 1'b1; accum = 1'b0; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        tick();
        chk("abort_done_later", 64'(done), 64'd0);
        run_op("after_abort", 32'd7, 32'd9, 1'b0, 64'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
